closest_hit_sequencer: RTL and testbench

//  Initiator side of the ray/triangle intersection interface. For one ray it streams

---
 rtl/closest_hit_sequencer_if.sv | 40 ++++
 rtl/closest_hit_sequencer.sv | 151 +++++++++++++++
 tb/tb_closest_hit_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/closest_hit_sequencer_if.sv
// Signal bundle between the closest-hit sequencer and its neighbours: the ray
// controller, triangle memory, the intersection pipeline and the hit consumer.
interface closest_hit_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic                     i_start;
  logic [0:1][0:2][31:0]    i_ray;
  logic [ADDR_W-1:0]        i_tri_base;
  logic [ADDR_W-1:0]        i_tri_count;
  logic                     o_busy;
  logic                     o_tri_rd;
  logic [ADDR_W-1:0]        o_tri_addr;
  logic [0:2][0:2][31:0]    i_tri_data;
  logic                     o_isect_en;
  logic [0:2][0:2][31:0]    o_isect_tri;
  logic [0:1][0:2][31:0]    o_isect_ray;
  logic signed [31:0]       i_isect_t;
  logic                     i_isect_result;
  logic                     i_isect_valid;
  logic                     o_hit_valid;
  logic                     i_hit_ready;
  logic                     o_hit;
  logic signed [31:0]       o_hit_t;
  logic [ADDR_W-1:0]        o_hit_idx;
  logic                     o_err;

  modport master (
    input  i_start, i_ray, i_tri_base, i_tri_count, i_tri_data,
           i_isect_t, i_isect_result, i_isect_valid, i_hit_ready,
    output o_busy, o_tri_rd, o_tri_addr, o_isect_en, o_isect_tri, o_isect_ray,
           o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_err
  );

  modport slave (
    output i_start, i_ray, i_tri_base, i_tri_count, i_tri_data,
           i_isect_t, i_isect_result, i_isect_valid, i_hit_ready,
    input  o_busy, o_tri_rd, o_tri_addr, o_isect_en, o_isect_tri, o_isect_ray,
           o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_err
  );
endinterface

// File: rtl/closest_hit_sequencer.sv
// Streams one ray's triangles into the intersection pipeline, reduces the in-order
// responses to the closest hit and offers it on a valid/ready handshake.
module closest_hit_sequencer #(
  parameter int                 ADDR_W  = 12,
  parameter int                 TIMEOUT = 256,
  parameter logic signed [31:0] T_MAX   = 32'sh7fffffff
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  closest_hit_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [0:1][0:2][31:0] ray;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     count;
  logic [ADDR_W-1:0]     issue_cnt;
  logic [ADDR_W-1:0]     resp_cnt;
  logic [ADDR_W-1:0]     tri_addr;
  logic [ADDR_W-1:0]     best_idx;
  logic signed [31:0]    best_t;
  logic [WD_W-1:0]       wd;
  logic                  hit;
  logic                  err;
  logic                  busy;
  logic                  tri_rd;
  logic                  isect_en;
  logic                  hit_valid;
  logic                  last_issue;
  logic                  resp_done;
  logic                  timeout;
  logic                  better;

  assign last_issue = (issue_cnt == (count - ADDR_W'(1)));
  // Widened by one bit so a full 2^ADDR_W-1 count cannot wrap the completion test.
  assign resp_done  = (({1'b0, resp_cnt} + {{ADDR_W{1'b0}}, bus.i_isect_valid}) == {1'b0, count});
  assign timeout    = !bus.i_isect_valid && (wd == WD_W'(TIMEOUT - 1));
  assign better     = bus.i_isect_valid && bus.i_isect_result && (bus.i_isect_t < best_t);

  assign bus.o_busy      = busy;
  assign bus.o_tri_rd    = tri_rd;
  assign bus.o_tri_addr  = tri_addr;
  assign bus.o_isect_en  = isect_en;
  assign bus.o_isect_tri = isect_en ? bus.i_tri_data : {9{32'h0000_0000}};
  assign bus.o_isect_ray = ray;
  assign bus.o_hit_valid = hit_valid;
  assign bus.o_hit       = hit;
  assign bus.o_hit_t     = best_t;
  assign bus.o_hit_idx   = best_idx;
  assign bus.o_err       = err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.i_start) state_next = (bus.i_tri_count == {ADDR_W{1'b0}}) ? RESULT : ISSUE;
        else             state_next = IDLE;
      end
      ISSUE: begin
        if (last_issue) state_next = DRAIN;
        else            state_next = ISSUE;
      end
      DRAIN: begin
        if (resp_done || timeout) state_next = RESULT;
        else                      state_next = DRAIN;
      end
      RESULT: begin
        if (bus.i_hit_ready) state_next = IDLE;
        else                 state_next = RESULT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: issue address, response reduction, watchdog and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ray       <= {6{32'h0000_0000}};
      base      <= {ADDR_W{1'b0}};
      count     <= {ADDR_W{1'b0}};
      issue_cnt <= {ADDR_W{1'b0}};
      resp_cnt  <= {ADDR_W{1'b0}};
      tri_addr  <= {ADDR_W{1'b0}};
      best_idx  <= {ADDR_W{1'b0}};
      best_t    <= 32'sh0000_0000;
      wd        <= {WD_W{1'b0}};
      hit       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      tri_rd    <= 1'b0;
      isect_en  <= 1'b0;
      hit_valid <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      tri_rd    <= (state_next == ISSUE);
      isect_en  <= tri_rd;
      hit_valid <= (state_next == RESULT);
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            ray       <= bus.i_ray;
            base      <= bus.i_tri_base;
            count     <= bus.i_tri_count;
            tri_addr  <= bus.i_tri_base;
            issue_cnt <= {ADDR_W{1'b0}};
            resp_cnt  <= {ADDR_W{1'b0}};
            best_idx  <= {ADDR_W{1'b0}};
            best_t    <= T_MAX;
            wd        <= {WD_W{1'b0}};
            hit       <= 1'b0;
            err       <= 1'b0;
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE) begin
            issue_cnt <= issue_cnt + ADDR_W'(1);
            tri_addr  <= tri_addr + ADDR_W'(1);
          end
          if (bus.i_isect_valid) resp_cnt <= resp_cnt + ADDR_W'(1);
          if (better) begin
            best_t   <= bus.i_isect_t;
            best_idx <= base + resp_cnt;
            hit      <= 1'b1;
          end
          // The watchdog only runs in DRAIN and restarts on every response.
          if (state == ISSUE || bus.i_isect_valid) wd <= {WD_W{1'b0}};
          else                                     wd <= wd + WD_W'(1);
          if (state == DRAIN && timeout && !resp_done) err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_closest_hit_sequencer.sv
// Directed bench for closest_hit_sequencer: a one-cycle-latency triangle memory
// model plus hand-timed intersection responses, checked with immediate assertions.
module tb_closest_hit_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] TMAX = 32'h7fff_ffff;

  closest_hit_sequencer_if #(.ADDR_W(12)) bus ();

  closest_hit_sequencer #(.ADDR_W(12), .TIMEOUT(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [0:2][0:2][31:0] tri_of(input logic [11:0] a);
    logic [0:2][0:2][31:0] w;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        w[v][c] = {a, 4'(v), 4'(c), 12'h5A5};
    return w;
  endfunction

  // Triangle memory: data follows the read strobe by one cycle.
  always @(posedge clk) bus.i_tri_data <= bus.o_tri_rd ? tri_of(bus.o_tri_addr) : {9{32'h0}};

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_resp(input logic r, input logic [31:0] t);
    bus.i_isect_valid  = 1'b1;
    bus.i_isect_result = r;
    bus.i_isect_t      = t;
    step();
    bus.i_isect_valid  = 1'b0;
    bus.i_isect_result = 1'b0;
  endtask

  task automatic start_op(input logic [11:0] b, input logic [11:0] n);
    bus.i_tri_base  = b;
    bus.i_tri_count = n;
    bus.i_start     = 1'b1;
    step();
    bus.i_start     = 1'b0;
  endtask

  logic [0:1][0:2][31:0] ray_a;
  logic [11:0]           a_exp;

  initial begin
    bus.i_start = 1'b0;  bus.i_ray = {6{32'h0}};
    bus.i_tri_base = 12'h000;  bus.i_tri_count = 12'h000;
    bus.i_tri_data = {9{32'h0}};
    bus.i_isect_t = 32'h0;  bus.i_isect_result = 1'b0;  bus.i_isect_valid = 1'b0;
    bus.i_hit_ready = 1'b0;
    ray_a = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
             32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000};
    repeat (3) step();
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_rd", bus.o_tri_rd, 1'b0);
    check("rst_en", bus.o_isect_en, 1'b0);
    check("rst_valid", bus.o_hit_valid, 1'b0);
    check("rst_hit_t", bus.o_hit_t, 32'h0);
    rst = 1'b0;
    step();

    // T1: closest of two hits, miss ignored
    bus.i_ray = ray_a;
    start_op(12'h010, 12'd3);
    bus.i_ray = {6{32'h0}};
    check("t1_rd0", bus.o_tri_rd, 1'b1);
    check("t1_addr0", bus.o_tri_addr, 12'h010);
    check("t1_busy", bus.o_busy, 1'b1);
    check("t1_ray", bus.o_isect_ray, ray_a);
    step();
    check("t1_en1", bus.o_isect_en, 1'b1);
    check("t1_tri1", bus.o_isect_tri, tri_of(12'h010));
    send_resp(1'b1, 32'h0002_0000);
    check("t1_addr2", bus.o_tri_addr, 12'h012);
    check("t1_tri2", bus.o_isect_tri, tri_of(12'h011));
    send_resp(1'b1, 32'h0000_8000);
    check("t1_drain_rd", bus.o_tri_rd, 1'b0);
    check("t1_drain_valid", bus.o_hit_valid, 1'b0);
    send_resp(1'b0, 32'h0000_1000);
    check("t1_valid", bus.o_hit_valid, 1'b1);
    check("t1_hit", bus.o_hit, 1'b1);
    check("t1_t", bus.o_hit_t, 32'h0000_8000);
    check("t1_idx", bus.o_hit_idx, 12'h011);
    check("t1_err", bus.o_err, 1'b0);
    bus.i_hit_ready = 1'b1;
    step();
    bus.i_hit_ready = 1'b0;
    check("t1_done_valid", bus.o_hit_valid, 1'b0);
    check("t1_done_busy", bus.o_busy, 1'b0);

    // T2: empty triangle list
    start_op(12'h050, 12'd0);
    check("t2_valid", bus.o_hit_valid, 1'b1);
    check("t2_rd", bus.o_tri_rd, 1'b0);
    check("t2_hit", bus.o_hit, 1'b0);
    check("t2_t", bus.o_hit_t, TMAX);
    check("t2_idx", bus.o_hit_idx, 12'h000);
    bus.i_hit_ready = 1'b1;
    step();
    bus.i_hit_ready = 1'b0;
    check("t2_en", bus.o_isect_en, 1'b0);
    check("t2_done", bus.o_hit_valid, 1'b0);

    // T3: equal t at base+4 and base+5 keeps base+4; responses all in DRAIN
    start_op(12'h100, 12'd6);
    repeat (6) step();
    check("t3_drain_rd", bus.o_tri_rd, 1'b0);
    send_resp(1'b0, 32'h0000_0100);
    send_resp(1'b1, 32'h0003_0000);
    send_resp(1'b0, 32'h0000_0200);
    send_resp(1'b0, 32'h0000_0300);
    send_resp(1'b1, 32'h0001_0000);
    check("t3_not_yet", bus.o_hit_valid, 1'b0);
    send_resp(1'b1, 32'h0001_0000);
    check("t3_valid", bus.o_hit_valid, 1'b1);
    check("t3_t", bus.o_hit_t, 32'h0001_0000);
    check("t3_idx", bus.o_hit_idx, 12'h104);
    bus.i_hit_ready = 1'b1;
    step();
    bus.i_hit_ready = 1'b0;

    // T4: address wrap, one-cycle issue offset
    start_op(12'hFFE, 12'd4);
    for (int i = 0; i < 6; i++) begin
      a_exp = 12'hFFE + 12'(i);
      check($sformatf("t4_rd%0d", i), bus.o_tri_rd, (i < 4));
      if (i < 4) check($sformatf("t4_addr%0d", i), bus.o_tri_addr, a_exp);
      check($sformatf("t4_en%0d", i), bus.o_isect_en, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4)
        check($sformatf("t4_tri%0d", i), bus.o_isect_tri, tri_of(a_exp - 12'd1));
      step();
    end
    repeat (4) send_resp(1'b0, 32'h0000_0010);
    check("t4_valid", bus.o_hit_valid, 1'b1);
    check("t4_hit", bus.o_hit, 1'b0);
    check("t4_t", bus.o_hit_t, TMAX);
    check("t4_idx", bus.o_hit_idx, 12'h000);
    bus.i_hit_ready = 1'b1;
    step();
    bus.i_hit_ready = 1'b0;

    // T5: missing response triggers the watchdog after 64 idle cycles
    start_op(12'h200, 12'd3);
    step();
    send_resp(1'b1, 32'h0000_5000);
    step();
    send_resp(1'b0, 32'h0000_0000);
    repeat (63) step();
    check("t5_early", bus.o_hit_valid, 1'b0);
    step();
    check("t5_valid", bus.o_hit_valid, 1'b1);
    check("t5_err", bus.o_err, 1'b1);
    check("t5_hit", bus.o_hit, 1'b1);
    check("t5_t", bus.o_hit_t, 32'h0000_5000);
    check("t5_idx", bus.o_hit_idx, 12'h200);

    // T6: held result stays stable, extra start and stray response ignored
    bus.i_start = 1'b1;
    bus.i_tri_base = 12'h300;
    bus.i_tri_count = 12'd2;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send_resp(1'b1, 32'h0000_0001);
      else step();
      check($sformatf("t6_valid%0d", i), bus.o_hit_valid, 1'b1);
      check($sformatf("t6_t%0d", i), bus.o_hit_t, 32'h0000_5000);
      check($sformatf("t6_idx%0d", i), bus.o_hit_idx, 12'h200);
      check($sformatf("t6_err%0d", i), bus.o_err, 1'b1);
    end
    bus.i_start = 1'b0;
    bus.i_hit_ready = 1'b1;
    step();
    bus.i_hit_ready = 1'b0;
    check("t6_idle", bus.o_busy, 1'b0);
    step();
    check("t6_no_restart", bus.o_tri_rd, 1'b0);

    // Reset in the middle of ISSUE
    bus.i_ray = ray_a;
    start_op(12'h300, 12'd5);
    step();
    check("t6_issue", bus.o_tri_rd, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_rd", bus.o_tri_rd, 1'b0);
    check("t6_rst_en", bus.o_isect_en, 1'b0);
    check("t6_rst_busy", bus.o_busy, 1'b0);
    check("t6_rst_ray", bus.o_isect_ray, {6{32'h0}});
    send_resp(1'b1, 32'h0000_0002);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_post_valid%0d", i), bus.o_hit_valid, 1'b0);
      check($sformatf("t6_post_busy%0d", i), bus.o_busy, 1'b0);
      step();
    end
    check("t6_post_t", bus.o_hit_t, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
